// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector with overlap/non-overlap modes and a Mealy match flag.
// Optional saturating match counter enabled by defining SEQ_DETECTOR_PARAM_CNT_EN.
module seq_detector_param #(
    parameter int                 MAX_LEN = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0001_1101,
    parameter int                 DEF_LEN = 5,
    parameter int                 CNT_W   = 8,
    localparam int                LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               x_vld,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_ovl,
    output logic               z,
    output logic               z_r,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN - 1);

    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;
    logic               ovl_q;
    logic [MAX_LEN-2:0] hist;
    logic [LW-1:0]      fill;

    logic [MAX_LEN-1:0] win;
    logic [MAX_LEN-1:0] mask;
    logic               hit;
    logic [LW-1:0]      len_c;

    // Window ends with the current bit; only the low len_q bits take part in the compare.
    always_comb begin
        win  = {hist, x};
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_q));
        hit = (((win ^ pat_q) & mask) == '0);
        z   = !rst && x_vld && !cfg_load && (fill >= (len_q - 1'b1)) && hit;
    end

    always_comb begin
        if (cfg_len == '0)
            len_c = LW'(1);
        else if (cfg_len > LW'(MAX_LEN))
            len_c = LW'(MAX_LEN);
        else
            len_c = cfg_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= DEF_PAT;
            len_q <= LW'(DEF_LEN);
            ovl_q <= 1'b0;
            hist  <= '0;
            fill  <= '0;
            z_r   <= 1'b0;
        end else begin
            z_r <= z;
            if (cfg_load) begin
                pat_q <= cfg_pat;
                len_q <= len_c;
                ovl_q <= cfg_ovl;
                fill  <= '0;
            end else if (x_vld) begin
                hist <= win[MAX_LEN-2:0];
                // Non-overlapping: a match retires every bit it used.
                if (z && !ovl_q)
                    fill <= '0;
                else if (fill != FILL_MAX)
                    fill <= fill + 1'b1;
            end
        end
    end

`ifdef SEQ_DETECTOR_PARAM_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || cfg_load)
            cnt_q <= '0;
        else if (z && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: per-cycle expected z/z_r/match_cnt queued at drive time.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst, x, x_vld, cfg_load, cfg_ovl;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LW-1:0]      cfg_len;
    logic               z, z_r;
    logic [CNT_W-1:0]   match_cnt;

    typedef struct {
        logic             ez, oz, ozr;
        logic [CNT_W-1:0] ec, oc;
    } rec_t;

    rec_t             sb[$];
    logic [CNT_W-1:0] cnt_m;
    int               vecs = 0;
    int               errs = 0;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .DEF_PAT(8'b0001_1101), .DEF_LEN(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .x(x), .x_vld(x_vld), .cfg_load(cfg_load),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .z(z), .z_r(z_r), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    // One cycle: drive, sample z mid-cycle, sample registered outputs after the edge.
    task automatic apply(input logic v, input logic b, input logic ez);
        rec_t r;
        x_vld = v;
        x     = b;
        @(negedge clk);
        r.ez = ez;
        r.oz = z;
`ifdef SEQ_DETECTOR_PARAM_CNT_EN
        if (rst || cfg_load)
            cnt_m = '0;
        else if (ez && cnt_m != {CNT_W{1'b1}})
            cnt_m = cnt_m + 1'b1;
`else
        cnt_m = '0;
`endif
        r.ec = cnt_m;
        @(posedge clk);
        #1;
        r.ozr = z_r;
        r.oc  = match_cnt;
        sb.push_back(r);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input logic o);
        cfg_pat  = p;
        cfg_len  = l;
        cfg_ovl  = o;
        cfg_load = 1'b1;
        apply(1'b1, 1'b1, 1'b0);
        cfg_load = 1'b0;
    endtask

    task automatic test_reset;
        rec_t r;
        rst = 1'b1;
        load(8'b0000_0101, 3, 1'b1);
        apply(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            vecs++;
            if (r.oz !== r.ez || r.ozr !== r.ez || r.oc !== r.ec) begin
                errs++;
                $display("FAIL reset: z=%b z_r=%b cnt=%0d, want z=%b z_r=%b cnt=%0d", r.oz, r.ozr, r.oc, r.ez, r.ez, r.ec);
            end
        end
    endtask

    task automatic test_default;
        rec_t r;
        logic [9:0] s, e;
        s = 10'b11101_11101;
        s = 10'b1110111101;
        e = 10'b0000100001;
        for (int i = 9; i >= 0; i--) apply(1'b1, s[i], e[i]);
        apply(1'b0, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            vecs++;
            if (r.oz !== r.ez || r.ozr !== r.ez || r.oc !== r.ec) begin
                errs++;
                $display("FAIL default_11101: z=%b z_r=%b cnt=%0d, want z=%b z_r=%b cnt=%0d", r.oz, r.ozr, r.oc, r.ez, r.ez, r.ec);
            end
        end
    endtask

    task automatic test_overlap;
        rec_t r;
        logic [4:0] s, e_ov, e_no;
        s    = 5'b10101;
        e_ov = 5'b00101;
        e_no = 5'b00100;
        load(8'b0000_0101, 3, 1'b1);
        for (int i = 4; i >= 0; i--) apply(1'b1, s[i], e_ov[i]);
        load(8'b0000_0101, 3, 1'b0);
        for (int i = 4; i >= 0; i--) apply(1'b1, s[i], e_no[i]);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            vecs++;
            if (r.oz !== r.ez || r.ozr !== r.ez || r.oc !== r.ec) begin
                errs++;
                $display("FAIL overlap_101: z=%b z_r=%b cnt=%0d, want z=%b z_r=%b cnt=%0d", r.oz, r.ozr, r.oc, r.ez, r.ez, r.ec);
            end
        end
    endtask

    task automatic test_gaps;
        rec_t r;
        rst = 1'b1;
        apply(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            vecs++;
            if (r.oz !== r.ez || r.ozr !== r.ez || r.oc !== r.ec) begin
                errs++;
                $display("FAIL vld_gaps: z=%b z_r=%b cnt=%0d, want z=%b z_r=%b cnt=%0d", r.oz, r.ozr, r.oc, r.ez, r.ez, r.ec);
            end
        end
    endtask

    task automatic test_mid_reset;
        rec_t r;
        logic [5:0] s, e;
        s = 6'b111101;
        e = 6'b000001;
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        apply(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 5; i >= 0; i--) apply(1'b1, s[i], e[i]);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            vecs++;
            if (r.oz !== r.ez || r.ozr !== r.ez || r.oc !== r.ec) begin
                errs++;
                $display("FAIL mid_reset: z=%b z_r=%b cnt=%0d, want z=%b z_r=%b cnt=%0d", r.oz, r.ozr, r.oc, r.ez, r.ez, r.ec);
            end
        end
    endtask

    task automatic test_len_clamp;
        rec_t r;
        logic [15:0] s, e;
        // len 0 -> 1: every 1 matches, non-overlapping mode included
        load(8'b0000_0001, 0, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        // len 15 -> 8: the last 7 bits alone must not match
        load(8'b1011_0011, 15, 1'b1);
        s = 16'b0011_0011_1011_0011;
        e = 16'b0000_0000_0000_0001;
        for (int i = 15; i >= 0; i--) apply(1'b1, s[i], e[i]);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            vecs++;
            if (r.oz !== r.ez || r.ozr !== r.ez || r.oc !== r.ec) begin
                errs++;
                $display("FAIL len_clamp: z=%b z_r=%b cnt=%0d, want z=%b z_r=%b cnt=%0d", r.oz, r.ozr, r.oc, r.ez, r.ez, r.ec);
            end
        end
    endtask

    task automatic test_counter;
        rec_t r;
        load(8'b0000_0001, 1, 1'b1);
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 1'b1);
        apply(1'b0, 1'b1, 1'b0);
        load(8'b0000_0001, 1, 1'b1);
        apply(1'b1, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            vecs++;
            if (r.oz !== r.ez || r.ozr !== r.ez || r.oc !== r.ec) begin
                errs++;
                $display("FAIL counter_sat: z=%b z_r=%b cnt=%0d, want z=%b z_r=%b cnt=%0d", r.oz, r.ozr, r.oc, r.ez, r.ez, r.ec);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        x        = 1'b0;
        x_vld    = 1'b0;
        cfg_load = 1'b0;
        cfg_pat  = '0;
        cfg_len  = '0;
        cfg_ovl  = 1'b0;
        cnt_m    = '0;
        @(posedge clk);
        #1;
        test_reset;
        test_default;
        test_overlap;
        test_gaps;
        test_mid_reset;
        test_len_clamp;
        test_counter;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning maximum pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter DEF_PAT, default 8'b0001_1101, meaning pattern loaded at reset (LSB = last bit received).
REQ-003 SHALL have parameter DEF_LEN, default 5, meaning pattern length loaded at reset.
REQ-004 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port x, input, 1, serial data bit.
REQ-008 SHALL have port x_vld, input, 1, x qualifier; the bit is consumed only when high.
REQ-009 SHALL have port cfg_load, input, 1, a one-cycle strobe that captures cfg_pat, cfg_len and cfg_ovl.
REQ-010 SHALL have port cfg_pat, input, MAX_LEN, the pattern; bit len-1 is the first received and bit 0 the last.
REQ-011 SHALL have port cfg_len, input, $clog2(MAX_LEN+1), the pattern length.
REQ-012 SHALL have port cfg_ovl, input, 1, where 1 selects overlapping detection and 0 selects non-overlapping.
REQ-013 SHALL have port z, output, 1, the Mealy match flag, combinational from state and x.
REQ-014 SHALL have port z_r, output, 1, which is z registered one cycle later.
REQ-015 SHALL have port match_cnt, output, CNT_W, a saturating count of matches.

Function
REQ-016 SHALL hold the captured configuration in pat_q, len_q and ovl_q; cfg_len=0 SHALL be captured as 1 and cfg_len>MAX_LEN as MAX_LEN.
REQ-017 SHALL keep a history register hist of MAX_LEN-1 bits and a fill counter fill that saturates at MAX_LEN-1.
REQ-018 SHALL assert z when all hold: x_vld=1, cfg_load=0, fill>=len_q-1, and the low len_q bits of {hist,x} equal the low len_q bits of pat_q.
REQ-019 On a consumed bit without a match, or with a match when ovl_q=1, SHALL shift x into hist LSB and increment fill (saturating).
REQ-020 On a consumed bit with a match when ovl_q=0, SHALL set fill to 0, so that no bit of a matched pattern contributes to a later match.
REQ-021 When x_vld=0, SHALL leave hist, fill and match_cnt unchanged and drive z=0.
REQ-022 On cfg_load=1, SHALL capture the configuration, clear fill and match_cnt, and ignore x that cycle, with z=0.
REQ-023 With len_q=1, SHALL assert z on every consumed bit equal to pat_q[0], in both modes.
REQ-024 SHALL set z_r to the value of z sampled at the previous rising clk edge.

Reset
REQ-025 On rst=1 at a rising clk edge, SHALL reset to pat_q=DEF_PAT, len_q=DEF_LEN, ovl_q=0, hist=0, fill=0, z_r=0 and match_cnt=0.
REQ-026 While rst=1, SHALL force z=0; rst SHALL take priority over cfg_load and x_vld, and reset applied mid-pattern SHALL discard the partial match.

Configuration
REQ-027 SHALL use macro SEQ_DETECTOR_PARAM_CNT_EN to select the counter.
- Defined: match_cnt increments by 1 on each cycle with z=1 and holds at 2^CNT_W-1.
- Undefined: no counter register is built and match_cnt is tied to 0.

Verification
REQ-028 Reset defaults, ovl=0, x_vld=1, x stream 1,1,1,0,1,1,1,1,0,1 -> z=1 on the 5th and 10th bits only; z_r=1 one cycle after each.
REQ-029 Load pat=101, len=3, ovl=1, stream 1,0,1,0,1 -> z=1 on bits 3 and 5; with ovl=0 on the same stream -> z=1 on bit 3 only.
REQ-030 Pattern 11101 with x_vld low for 3 cycles between the 3rd and 4th bits -> z=1 on the 5th valid bit; z stays 0 while x_vld=0.
REQ-031 Stream 1,1,1,0, then rst=1 for one cycle, then 1 -> z=0 on that 1; a following full 11101 stream -> z=1 on its 5th bit.
REQ-032 Load cfg_len=0 with pat bit0=1, stream 1,0,1 -> z=1 on bits 1 and 3; load cfg_len=15 with MAX_LEN=8 -> len_q=8.
REQ-033 With SEQ_DETECTOR_PARAM_CNT_EN and CNT_W=2, 5 matches -> match_cnt=3 (saturated); a cfg_load -> match_cnt=0; with the macro undefined -> match_cnt=0 throughout.
